// File: rtl/fifo_fwft_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fifo_fwft_stream_if                                              |
// | Brief   : Write-side and read-side valid/ready stream bundle for the FIFO. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fifo_fwft_stream_if #(
    parameter int DWIDTH = 16
);
    logic [DWIDTH-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // master: the producer/consumer environment; slave: the FIFO itself
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/fifo_fwft_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fifo_fwft_stream                                                 |
// | Brief   : First-word-fall-through FIFO, valid/ready on both sides, sync-   |
// |           read RAM with output + prefetch registers, flush, thresholds.    |
// |           Define FIFO_HWM_EN to add the high_water port.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_fwft_stream #(
    parameter int DWIDTH        = 16,
    parameter int ADDR_WIDTH    = 7,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire                  flush,
    fifo_fwft_stream_if.slave    bus,
    output logic [ADDR_WIDTH:0]  data_count,
    output logic                 almost_full,
    output logic                 almost_empty
`ifdef FIFO_HWM_EN
    ,
    output logic [ADDR_WIDTH:0]  high_water
`endif
);

    localparam int                    c_DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   c_FULL_COUNT = (ADDR_WIDTH + 1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_AFULL      = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   c_AEMPTY     = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0]   c_ONE        = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   c_TWO        = (ADDR_WIDTH + 1)'(2);
    localparam logic [ADDR_WIDTH-1:0] c_PF_OFFSET  = ADDR_WIDTH'(2);

    generate
        if ((AFULL_THRESH > c_DEPTH) || (AEMPTY_THRESH >= c_DEPTH)) begin : g_bad_thresh
            $error("fifo_fwft_stream: threshold parameters out of range for DEPTH");
        end
    endgenerate

    // EMPTY: nothing held; ONE: head in out reg; STREAM: head + next in prefetch reg
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ONE    = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t                  state_q,  state_d;
    logic [ADDR_WIDTH:0]     count_q,  count_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DWIDTH-1:0]       out_q,    out_d;
    logic [DWIDTH-1:0]       pf_q,     pf_d;

    logic [DWIDTH-1:0]       mem [c_DEPTH];

    logic                    w_push;
    logic                    w_pop;
    logic                    w_wr_en;
    logic                    w_deep;
    logic [ADDR_WIDTH-1:0]   w_pf_addr;

    assign w_push    = bus.in_valid && bus.in_ready;
    assign w_pop     = bus.out_valid && bus.out_ready;
    assign w_wr_en   = w_push && !flush;
    assign w_deep    = (count_q > c_TWO);
    // rd_ptr addresses the head; the element two behind it refills the prefetch reg
    assign w_pf_addr = rd_ptr_q + c_PF_OFFSET;

    assign bus.out_data  = out_q;
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.in_ready  = (count_q != c_FULL_COUNT);
    assign data_count    = count_q;
    assign almost_full   = (count_q >= c_AFULL);
    assign almost_empty  = (count_q <= c_AEMPTY);

    // Every accepted word lands in RAM, so the registers only ever cache copies
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        out_d    = out_q;
        pf_d     = pf_q;
        state_d  = state_q;

        unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_ONE;
            2'b01:   count_d = count_q - c_ONE;
            default: count_d = count_q;
        endcase

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            ST_EMPTY: begin
                if (w_push) begin
                    out_d = bus.in_data;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    out_d = bus.in_data;
                end else if (w_push) begin
                    pf_d = bus.in_data;
                end
            end
            ST_STREAM: begin
                if (w_pop) begin
                    out_d = pf_q;
                    if (w_deep) begin
                        pf_d = mem[w_pf_addr];
                    end else if (w_push) begin
                        pf_d = bus.in_data;
                    end
                end
            end
            default: begin
                out_d = out_q;
            end
        endcase

        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d == c_ONE) begin
            state_d = ST_ONE;
        end else begin
            state_d = ST_STREAM;
        end

        // Flush wins over any handshake in the same cycle
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            out_q    <= '0;
            pf_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            out_q    <= out_d;
            pf_q     <= pf_d;
        end
    end

`ifdef FIFO_HWM_EN
    logic [ADDR_WIDTH:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (flush) begin
            hwm_d = '0;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign high_water = hwm_q;
`endif

    a_out_stable : assert property (
        @(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready && !flush) |=> $stable(bus.out_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_fwft_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fifo_fwft_stream                                              |
// | Brief   : Queue-model bench for fifo_fwft_stream (ADDR_WIDTH=3).           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fifo_fwft_stream;

    localparam int c_DW    = 16;
    localparam int c_AW    = 3;
    localparam int c_DEPTH = 8;
    localparam int c_AF    = c_DEPTH - 4;
    localparam int c_AE    = 2;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              flush = 1'b0;
    logic [c_AW:0]     data_count;
    logic              almost_full;
    logic              almost_empty;
`ifdef FIFO_HWM_EN
    logic [c_AW:0]     high_water;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [c_DW-1:0] model_q[$];
    int              model_hwm = 0;

    fifo_fwft_stream_if #(.DWIDTH(c_DW)) bus ();

    fifo_fwft_stream #(
        .DWIDTH        (c_DW),
        .ADDR_WIDTH    (c_AW),
        .AFULL_THRESH  (c_AF),
        .AEMPTY_THRESH (c_AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus),
        .data_count   (data_count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef FIFO_HWM_EN
        ,
        .high_water   (high_water)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = model_q.size();
        check("data_count",   32'(data_count),    32'(sz));
        check("out_valid",    32'(bus.out_valid), 32'(sz != 0));
        check("in_ready",     32'(bus.in_ready),  32'(sz < c_DEPTH));
        check("almost_full",  32'(almost_full),   32'(sz >= c_AF));
        check("almost_empty", 32'(almost_empty),  32'(sz <= c_AE));
        if (sz != 0) begin
            check("out_data", 32'(bus.out_data), 32'(model_q[0]));
        end
`ifdef FIFO_HWM_EN
        check("high_water", 32'(high_water), 32'(model_hwm));
`endif
    endtask

    // Check the state left by the previous edge, then drive this cycle's inputs
    task automatic cycle(input logic iv, input logic [c_DW-1:0] d,
                         input logic ordy, input logic fl);
        bit do_push, do_pop;
        @(negedge clk);
        check_outputs();
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        if (fl) begin
            model_q.delete();
            model_hwm = 0;
        end else begin
            do_push = iv && (model_q.size() < c_DEPTH);
            do_pop  = ordy && (model_q.size() > 0);
            if (do_pop) begin
                void'(model_q.pop_front());
            end
            if (do_push) begin
                model_q.push_back(d);
            end
            if (model_q.size() > model_hwm) begin
                model_hwm = model_q.size();
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < c_DEPTH + 1; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Fill to full with the consumer stalled, then one blocked push
        for (int i = 1; i <= c_DEPTH; i++) begin
            cycle(1'b1, 16'(i), 1'b0, 1'b0);
        end
        cycle(1'b1, 16'h0099, 1'b0, 1'b0);
        for (int i = 0; i < c_DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Single word through an empty FIFO
        cycle(1'b1, 16'hABCD, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Sustained streaming, 25 pointer wraps
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 16'(16'h1000 + i), 1'b1, 1'b0);
        end
        drain();

        // Full with simultaneous push attempt and pop
        for (int i = 0; i < c_DEPTH; i++) begin
            cycle(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
        end
        cycle(1'b1, 16'h2FFF, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        drain();

        // Flush at count 5 together with push and pop
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
        end
        cycle(1'b1, 16'h3FFF, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 16'h3100, 1'b1, 1'b0);
        drain();

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0);
        end
        cycle(1'b1, 16'h4010, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        model_q.delete();
        model_hwm = 0;
        #1;
        check_outputs();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 16'h0042, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Random traffic in phases of differing producer/consumer bias
        for (int ph = 0; ph < 8; ph++) begin
            int pv, pr;
            pv = $urandom_range(10, 95);
            pr = $urandom_range(10, 95);
            for (int i = 0; i < 250; i++) begin
                cycle($urandom_range(0, 99) < pv, 16'($urandom),
                      $urandom_range(0, 99) < pr, $urandom_range(0, 99) == 0);
            end
        end
        cycle(1'b0, '0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
